// File: rtl/clock_pkg.sv
// BCD limits and the 24h -> 12h display conversion shared by the timekeeper.
package clock_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    typedef struct packed {
        logic       pm;
        logic [7:0] hh;
    } hour12_t;

    // True when v is a well-formed BCD byte not exceeding max_bcd.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_bcd);
        return (v[3:0] <= 4'd9) && (v <= max_bcd);
    endfunction

    function automatic hour12_t to_12h(input logic [7:0] hour_bcd);
        hour12_t    r;
        logic [4:0] bin;
        logic [4:0] h;
        bin  = 5'(hour_bcd[7:4]) * 5'd10 + 5'(hour_bcd[3:0]);
        r.pm = (bin >= 5'd12);
        h    = r.pm ? bin - 5'd12 : bin;
        if (h == 5'd0) begin
            h = 5'd12;
        end
        r.hh = (h >= 5'd10) ? {4'd1, 4'(h - 5'd10)} : {4'd0, h[3:0]};
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX_BCD with clear-over-increment priority.
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] count_o,
    output logic [7:0] next_o,
    output logic       wrap_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // High whenever an increment this cycle would roll over to 00.
    assign wrap_o  = (cnt_q == MAX_BCD);
    assign count_o = cnt_q;
    assign next_o  = cnt_d;

    // NOTE: cnt_d is given its hold value first so no path through this block can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (wrap_o) begin
                cnt_d = '0;
            end else if (cnt_q[3:0] == 4'd9) begin
                cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
            end else begin
                cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// Time-of-day core: seconds prescaler, BCD h:m:s chain, 12/24h display and alarm flag.
module bcd_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter bit ALARM_EN_HW = 1'b1
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       run,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic       alarm_clr,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic [3:0] hours2,
    output logic [3:0] hours1,
    output logic [3:0] mins2,
    output logic [3:0] mins1,
    output logic [7:0] secs_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       alarm_ring
);

    localparam int              PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          ring_q, ring_d;

    logic          tick, edit, auto_tick;
    logic [7:0]    secs_q, mins_q, hours_q;
    logic [7:0]    secs_next, mins_next, hours_next;
    logic          secs_wrap, mins_wrap;
    logic          day_wrap_unused;
    logic          alarm_valid, alarm_hit;
    hour12_t       disp12;

    assign tick      = run && (presc_q == PRESC_LAST);
    assign edit      = inc_min || inc_hour;
    // A button edit in the tick cycle swallows the tick and all of its carries.
    assign auto_tick = tick && !edit;

    bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_secs (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .inc_i     (auto_tick),
        .clr_i     (edit),
        .count_o   (secs_q),
        .next_o    (secs_next),
        .wrap_o    (secs_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_mins (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .inc_i     (inc_min || (auto_tick && secs_wrap)),
        .clr_i     (1'b0),
        .count_o   (mins_q),
        .next_o    (mins_next),
        .wrap_o    (mins_wrap)
    );

    // Midnight rollover has no consumer at this level.
    bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hours (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .inc_i     (inc_hour || (auto_tick && secs_wrap && mins_wrap)),
        .clr_i     (1'b0),
        .count_o   (hours_q),
        .next_o    (hours_next),
        .wrap_o    (day_wrap_unused)
    );

    assign alarm_valid = bcd_ok(alarm_hh, HOUR_MAX) && bcd_ok(alarm_mm, MIN_MAX);
    assign alarm_hit   = auto_tick && alarm_en && alarm_valid && (secs_next == 8'h00)
                       && (mins_next == alarm_mm) && (hours_next == alarm_hh);
    assign sec_pulse_d = tick;

    always_comb begin
        presc_d = presc_q;
        if (edit || tick) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        ring_d = ring_q;
        if (!ALARM_EN_HW) begin
            ring_d = 1'b0;
        end else if (alarm_clr || !alarm_en) begin
            ring_d = 1'b0;
        end else if (alarm_hit) begin
            ring_d = 1'b1;
        end
    end

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            presc_q     <= '0;
            sec_pulse_q <= 1'b0;
            ring_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_pulse_q <= sec_pulse_d;
            ring_q      <= ring_d;
        end
    end

    assign disp12     = to_12h(hours_q);
    assign {hours2, hours1} = mode_12h ? disp12.hh : hours_q;
    assign {mins2, mins1}   = mins_q;
    assign secs_bcd   = secs_q;
    assign pm         = disp12.pm;
    assign sec_pulse  = sec_pulse_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Scoreboard bench for bcd_timekeeper at CLK_HZ=4: driver queues expectations, monitor compares.
module tb_bcd_timekeeper;

    logic       clk = 1'b0;
    logic       reset, run, inc_min, inc_hour, mode_12h, alarm_en, alarm_clr;
    logic [7:0] alarm_hh, alarm_mm;
    logic [3:0] hours2, hours1, mins2, mins1;
    logic [7:0] secs_bcd;
    logic       pm, sec_pulse, alarm_ring;

    always #5 clk = ~clk;

    bcd_timekeeper #(.CLK_HZ(4), .ALARM_EN_HW(1'b1)) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .run        (run),
        .inc_min    (inc_min),
        .inc_hour   (inc_hour),
        .mode_12h   (mode_12h),
        .alarm_en   (alarm_en),
        .alarm_clr  (alarm_clr),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .hours2     (hours2),
        .hours1     (hours1),
        .mins2      (mins2),
        .mins1      (mins1),
        .secs_bcd   (secs_bcd),
        .pm         (pm),
        .sec_pulse  (sec_pulse),
        .alarm_ring (alarm_ring)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] mask;
        logic [7:0] hh, mm, ss;
        logic       pm, pulse, ring;
    } exp_t;

    localparam logic [5:0] M_HH = 6'h01, M_MM = 6'h02, M_SS = 6'h04;
    localparam logic [5:0] M_PM = 6'h08, M_P  = 6'h10, M_R  = 6'h20;
    localparam logic [5:0] M_TIME = M_HH | M_MM | M_SS | M_PM;
    localparam logic [5:0] M_ALL  = 6'h3F;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic want(input string nm, input logic [5:0] m, input logic [7:0] hh,
                        input logic [7:0] mm, input logic [7:0] ss,
                        input logic pm_v, input logic p_v, input logic r_v);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.mask = m;
        e.hh = hh; e.mm = mm; e.ss = ss; e.pm = pm_v; e.pulse = p_v; e.ring = r_v;
        sb.push_back(e);
    endtask

    // Monitor: digit-range invariant every cycle, then drain expectations due now.
    always @(negedge clk) begin
        exp_t       e;
        bit         bad;
        logic [7:0] a_hh, a_mm;
        a_hh = {hours2, hours1};
        a_mm = {mins2, mins1};
        n_vec++;
        if (hours1 > 4'd9 || hours2 > 4'd2 || mins1 > 4'd9 || mins2 > 4'd5 ||
            secs_bcd[3:0] > 4'd9 || secs_bcd[7:4] > 4'd5) begin
            n_bad++;
            $display("FAIL digit_range cyc %0d: got %h:%h:%h, required every digit in range", cyc, a_hh, a_mm, secs_bcd);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            bad = (e.cyc != cyc);
            if (e.mask[0] && a_hh !== e.hh)         bad = 1;
            if (e.mask[1] && a_mm !== e.mm)         bad = 1;
            if (e.mask[2] && secs_bcd !== e.ss)     bad = 1;
            if (e.mask[3] && pm !== e.pm)           bad = 1;
            if (e.mask[4] && sec_pulse !== e.pulse) bad = 1;
            if (e.mask[5] && alarm_ring !== e.ring) bad = 1;
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL %s cyc %0d/%0d mask %b: got %h:%h:%h pm=%b pulse=%b ring=%b, required %h:%h:%h pm=%b pulse=%b ring=%b",
                         e.name, cyc, e.cyc, e.mask, a_hh, a_mm, secs_bcd, pm, sec_pulse, alarm_ring,
                         e.hh, e.mm, e.ss, e.pm, e.pulse, e.ring);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic press_hour(input int n);
        repeat (n) begin
            inc_hour = 1'b1; step(); inc_hour = 1'b0;
        end
    endtask

    task automatic press_min(input int n);
        repeat (n) begin
            inc_min = 1'b1; step(); inc_min = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got no end of stimulus, required finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        reset = 1'b1; run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; mode_12h = 1'b0;
        alarm_en = 1'b0; alarm_clr = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
        step(); step();

        // Reset state and first-second timing
        want("reset_state", M_ALL, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        step();
        mode_12h = 1'b1;
        want("reset_12h", M_HH | M_PM, 8'h12, 8'h00, 8'h00, 0, 0, 0);
        step();
        mode_12h = 1'b0;
        reset = 1'b0; run = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            want($sformatf("tick_c%0d", c), M_SS | M_P, 8'h00, 8'h00, 8'((c - 1) / 4), 0,
                 (c > 1 && (c - 1) % 4 == 0), 0);
            if (c < 17) step();
        end

        // Full carry chain 23:59:58 -> 00:00:00
        run = 1'b0;
        press_hour(23);
        want("preload_hour", M_TIME, 8'h23, 8'h00, 8'h00, 1, 0, 0);
        press_min(59);
        want("preload_min", M_TIME, 8'h23, 8'h59, 8'h00, 1, 0, 0);
        run = 1'b1;
        run_cycles(232);
        want("preload_58", M_TIME | M_P, 8'h23, 8'h59, 8'h58, 1, 1, 0);
        run_cycles(4);
        want("sec_59", M_TIME | M_P, 8'h23, 8'h59, 8'h59, 1, 1, 0);
        run_cycles(4);
        want("midnight", M_TIME | M_P, 8'h00, 8'h00, 8'h00, 0, 1, 0);
        run = 1'b0;

        // 12h display conversion
        step();
        mode_12h = 1'b1;
        want("h00_12h", M_HH | M_PM, 8'h12, 8'h00, 8'h00, 0, 0, 0);
        press_hour(12);
        want("h12_12h", M_HH | M_PM, 8'h12, 8'h00, 8'h00, 1, 0, 0);
        press_hour(1);
        want("h13_12h", M_TIME, 8'h01, 8'h00, 8'h00, 1, 0, 0);
        step();
        mode_12h = 1'b0;
        want("h13_24h", M_TIME, 8'h13, 8'h00, 8'h00, 1, 0, 0);
        press_hour(10);
        want("h23_24h", M_HH | M_PM, 8'h23, 8'h00, 8'h00, 1, 0, 0);
        step();
        mode_12h = 1'b1;
        want("h23_12h", M_HH | M_PM, 8'h11, 8'h00, 8'h00, 1, 0, 0);
        step();
        mode_12h = 1'b0;
        press_hour(1);
        want("hour_wrap", M_TIME, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // Minute edits, simultaneous edits, edit on the tick cycle
        press_hour(5);
        press_min(59);
        want("min_59", M_TIME, 8'h05, 8'h59, 8'h00, 0, 0, 0);
        press_min(1);
        want("min_wrap_no_carry", M_TIME, 8'h05, 8'h00, 8'h00, 0, 0, 0);
        press_min(59);
        inc_min = 1'b1; inc_hour = 1'b1; step(); inc_min = 1'b0; inc_hour = 1'b0;
        want("both_edits", M_TIME, 8'h06, 8'h00, 8'h00, 0, 0, 0);
        run = 1'b1;
        run_cycles(236);
        want("pre_edit_tick", M_TIME, 8'h06, 8'h00, 8'h59, 0, 0, 0);
        run_cycles(3);
        inc_min = 1'b1; step(); inc_min = 1'b0;
        want("edit_on_tick", M_TIME | M_P, 8'h06, 8'h01, 8'h00, 0, 1, 0);
        step();
        want("after_edit_tick", M_SS | M_P, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run = 1'b0;

        // Alarm: rise, enable-drop clear, manual edit, alarm_clr, clear-wins, invalid BCD
        press_hour(18);
        press_min(59);
        want("alarm_start", M_TIME | M_R, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        alarm_hh = 8'h00; alarm_mm = 8'h01; alarm_en = 1'b1; run = 1'b1;
        run_cycles(239);
        want("alarm_pre", M_TIME | M_R, 8'h00, 8'h00, 8'h59, 0, 0, 0);
        step();
        want("alarm_rise", M_TIME | M_P | M_R, 8'h00, 8'h01, 8'h00, 0, 1, 1);
        run_cycles(2);
        want("alarm_hold", M_R, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        run = 1'b0;
        alarm_en = 1'b0; step();
        want("alarm_en_off", M_R, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        alarm_en = 1'b1; step();
        want("alarm_stays_clear", M_R, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        press_min(59);
        press_min(1);
        want("manual_alarm_time", M_TIME | M_R, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        press_min(59);
        run = 1'b1;
        run_cycles(240);
        want("alarm_rise2", M_TIME | M_R, 8'h00, 8'h01, 8'h00, 0, 0, 1);
        alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
        want("alarm_clr", M_R, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run = 1'b0;
        press_min(59);
        run = 1'b1;
        run_cycles(239);
        alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
        want("clr_wins", M_TIME | M_R, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        run_cycles(4);
        want("clr_wins_hold", M_R, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        run = 1'b0;
        press_min(59);
        alarm_hh = 8'h2A;
        run = 1'b1;
        run_cycles(240);
        want("alarm_bad_bcd", M_TIME | M_R, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        run = 1'b0;

        // Reset mid-second at 12:34:56 with the alarm ringing
        press_hour(12);
        press_min(32);
        want("set_1233", M_TIME, 8'h12, 8'h33, 8'h00, 1, 0, 0);
        alarm_hh = 8'h12; alarm_mm = 8'h34; run = 1'b1;
        run_cycles(240);
        want("alarm_1234", M_TIME | M_R, 8'h12, 8'h34, 8'h00, 1, 0, 1);
        run_cycles(226);
        want("pre_reset", M_TIME | M_P | M_R, 8'h12, 8'h34, 8'h56, 1, 0, 1);
        reset = 1'b1; step();
        want("reset_mid", M_ALL, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        step();
        mode_12h = 1'b1;
        want("reset_mid_12h", M_HH | M_PM, 8'h12, 8'h00, 8'h00, 0, 0, 0);
        step();
        mode_12h = 1'b0;
        reset = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            want($sformatf("post_reset_c%0d", c), M_SS | M_P, 8'h00, 8'h00, 8'((c - 1) / 4), 0, (c == 5), 0);
            if (c < 5) step();
        end

        step();
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
